// File: rtl/serial_frame_receiver.sv
// Deserialises start/data/stop framed words from a one-bit-per-clock stream and
// offers them through a valid/ready holding register with framing-error and overrun flags.
module serial_frame_receiver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Serial_in,
  output logic [WIDTH-1:0] Data_out,
  output logic             Data_valid,
  input  logic             Data_ready,
  output logic             Frame_error,
  output logic             Overrun,
  output logic             Busy
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               busy_q, busy_d;
  logic               good_frame;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    ferr_d     = 1'b0;
    good_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (Serial_in) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_d[cnt_q] = Serial_in;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // An errored stop bit always returns to IDLE; it is never taken as a start bit.
        state_d = IDLE;
        if (Serial_in) begin
          ferr_d = 1'b1;
        end else begin
          good_frame = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Holding register: a same-edge handshake frees the slot for the new word.
    if (good_frame) begin
      if (!valid_q || Data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && Data_ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign Data_out    = data_q;
  assign Data_valid  = valid_q;
  assign Frame_error = ferr_q;
  assign Overrun     = ovr_q;
  assign Busy        = busy_q;

endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Downstream consumer of the 4-bit shift register's serial output `shift_out`.
- Samples the serial stream one bit per `CLK` rising edge.
- Recognises framed words (start bit, WIDTH data bits LSB-first, stop bit) and deserialises each into a parallel word.
- Presents the word to the next stage through a valid/ready holding register, reporting framing errors and overruns.

Parameters:
- WIDTH, 4, data bits per frame (≥2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- CLK  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high reset.
- Serial_in  input  1  serial stream, driven by shift register `shift_out`; idles at 0.
- Data_out  output  WIDTH  last accepted word, LSB = first data bit received.
- Data_valid  output  1  Data_out holds an unconsumed word.
- Data_ready  input  1  consumer accepts Data_out when Data_valid && Data_ready at a rising edge.
- Frame_error  output  1  one-cycle pulse: stop bit sampled as 1.
- Overrun  output  1  sticky: a good frame was dropped because the holding register was full.
- Busy  output  1  high while in DATA or STOP.

Behaviour:
- Reset (async, any state, mid-frame included):
  - FSM goes to IDLE; shift reg, counter, Data_out all 0.
  - Data_valid=0, Frame_error=0, Overrun=0, Busy=0.
  - Any partial frame is discarded.
- Frame format, one bit per clock: start=1, then WIDTH data bits LSB-first, then stop=0.
- FSM states:
  - IDLE:
    - Serial_in=1 at an edge → DATA, counter=0.
    - Serial_in=0 → stay in IDLE.
  - DATA:
    - Each edge shifts Serial_in into bit[counter] and increments counter.
    - When counter==WIDTH-1, the shift completes and the FSM moves to STOP.
  - STOP:
    - Serial_in=0: frame good → IDLE, word offered to the holding register.
    - Serial_in=1: Frame_error=1 for exactly one cycle; word discarded → IDLE.
    - The errored stop bit is never reinterpreted as a start bit.
    - Earliest next start bit is sampled at the edge after the return to IDLE.
- Latency:
  - Start bit sampled at edge k; data bits at edges k+1..k+WIDTH; stop bit at edge k+WIDTH+1.
  - Data_valid rises after edge k+WIDTH+1.
  - Back-to-back frames: the next start bit is at edge k+WIDTH+2 at the earliest.
- Holding register / handshake:
  - Data_out and Data_valid are registered and change only at edges.
  - Data_valid && Data_ready at an edge, no new good frame → Data_valid=0; Data_out is held.
  - Good frame completes while Data_valid=0 → load word, Data_valid=1.
  - Good frame and handshake at the same edge → load new word, Data_valid stays 1, no overrun.
  - Good frame while Data_valid=1 && Data_ready=0 → new word dropped, Data_out unchanged, Overrun=1.
  - Overrun is sticky until Reset.
  - Errored frames never touch Data_out, Data_valid or Overrun.
- Data_ready is ignored while Data_valid=0.
- Busy = (state != IDLE).

Test Plan (WIDTH=4):
- Reset asserted mid-DATA after 2 data bits:
  - All outputs 0 immediately, without a clock edge.
  - After release, Serial_in=0 for 5 cycles → Data_valid stays 0, Busy=0.
- Single frame, Serial_in=1,0,1,0,1,0 on consecutive edges, Data_ready=0:
  - Data_out=4'hA and Data_valid=1 after the 6th edge.
  - Frame_error=0, Overrun=0.
  - Data_ready=1 for one edge → Data_valid=0, Data_out stays 4'hA.
- Bad stop bit, Serial_in=1,1,1,1,1,1, then 0:
  - Frame_error pulses 1 for exactly one cycle after the 6th edge.
  - Data_valid stays 0.
  - FSM is in IDLE, not DATA, after the 7th edge.
- Back-to-back frames 4'h3 then 4'hC, Data_ready held 1:
  - Data_valid high one cycle with 4'h3, then one cycle with 4'hC.
  - Overrun=0.
- Overrun, frames 4'h5 then 4'h6 with Data_ready=0:
  - Data_out=4'h5 after the 2nd frame, Overrun=1.
  - A later handshake clears Data_valid but Overrun stays 1 until Reset.
- Simultaneous load and accept: Data_ready=1 exactly at the 2nd frame's stop edge:
  - Data_out=4'h6, Data_valid remains 1, Overrun=0.
